// File: rtl/cache_pkg.sv
// Shared request type, FSM states and default arbiter sizing for the cache request path.
package cache_pkg;

  localparam int ARB_NUM_CH     = 4;
  localparam int ARB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/cache_req_fifo.sv
// Per-channel request buffer; head is visible combinationally, no bypass when full.
module cache_req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = ARB_FIFO_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t head,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cache_req_arb.sv
// Round-robin arbiter from NUM_CH buffered channels onto one registered cache port.
// Optional per-channel grant counters: define CACHE_ARB_STATS_EN.
module cache_req_arb
  import cache_pkg::*;
#(
  parameter  int NUM_CH     = ARB_NUM_CH,
  parameter  int FIFO_DEPTH = ARB_FIFO_DEPTH,
  parameter  int CNT_W      = 16,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  req_t              req_i [NUM_CH],
  input  logic [NUM_CH-1:0] req_i_valid,
  output logic [NUM_CH-1:0] req_i_ready,
  output req_t              req_o,
  output logic              req_o_valid,
  input  logic              req_o_ready,
  output logic [CH_W-1:0]   req_o_ch
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NUM_CH-1:0][CNT_W-1:0] grant_cnt
`endif
);

  if (CNT_W < 1 || FIFO_DEPTH < 2 || NUM_CH < 2) begin : g_bad_cfg
    $error("cache_req_arb: bad parameters");
  end

  req_t              head [NUM_CH];
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W-1:0]   win_ch;
  logic              win_vld;
  logic              load;

  assign req_i_ready = ~full & {NUM_CH{~reset}};
  assign push        = req_i_valid & req_i_ready;
  assign req_o_valid = (state_q == HOLD);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    cache_req_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push[c]),
      .push_data(req_i[c]),
      .pop      (pop[c]),
      .head     (head[c]),
      .empty    (empty[c]),
      .full     (full[c])
    );
  end

  // First non-empty channel at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!win_vld && !empty[idx]) begin
        win_vld = 1'b1;
        win_ch  = CH_W'(idx);
      end
    end
  end

  assign rr_next = (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + 1'b1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (req_o_ready) begin
          load    = win_vld;
          state_d = win_vld ? HOLD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) pop[win_ch] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_o    <= '0;
      req_o_ch <= '0;
      rr_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        req_o    <= head[win_ch];
        req_o_ch <= win_ch;
        rr_ptr   <= rr_next;
      end
    end
  end

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (load && (grant_cnt[win_ch] != '1)) begin
      grant_cnt[win_ch] <= grant_cnt[win_ch] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_arb.sv
// Directed bench for cache_req_arb with a queue-based reference model.
module tb_cache_req_arb;
  import cache_pkg::*;

  localparam int NCH = 4;
  localparam int DEP = 2;
`ifdef CACHE_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  req_t           req_i [NCH];
  logic [NCH-1:0] req_i_valid = '0;
  logic [NCH-1:0] req_i_ready;
  req_t           req_o;
  logic           req_o_valid;
  logic           req_o_ready = 1'b0;
  logic [1:0]     req_o_ch;
`ifdef CACHE_ARB_STATS_EN
  logic [NCH-1:0][CW-1:0] grant_cnt;
`endif

  cache_req_arb #(
    .NUM_CH    (NCH),
    .FIFO_DEPTH(DEP),
    .CNT_W     (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_i),
    .req_i_valid(req_i_valid),
    .req_i_ready(req_i_ready),
    .req_o      (req_o),
    .req_o_valid(req_o_valid),
    .req_o_ready(req_o_ready),
    .req_o_ch   (req_o_ch)
`ifdef CACHE_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string n, logic [95:0] a, logic [95:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  function automatic req_t mkreq(int c, int n);
    req_t r;
    r       = '0;
    r.addr  = 32'(c * 256 + n);
    r.wdata = ~r.addr;
    r.we    = n[0];
    r.be    = 4'(n);
    return r;
  endfunction

  typedef struct {
    int   ch;
    req_t d;
  } em_t;

  req_t mq [NCH][$];
  em_t  emitted [$];
  logic m_v = 1'b0;
  req_t m_d = '0;
  int   m_c = 0;
  int   m_rr = 0;
  int   m_gnt [NCH];
  int   sz [NCH];
  int   w;
  bit   found;

  // Reference: channel queues, one held slot, round-robin pick.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_gnt[c] = 0;
      end
      emitted.delete();
      m_v  = 1'b0;
      m_d  = '0;
      m_c  = 0;
      m_rr = 0;
    end else begin
      for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
      if (m_v && req_o_ready) emitted.push_back('{m_c, m_d});
      if (!m_v || req_o_ready) begin
        found = 0;
        w = 0;
        for (int i = 0; i < NCH; i++) begin
          if (!found && sz[(m_rr + i) % NCH] > 0) begin
            found = 1;
            w = (m_rr + i) % NCH;
          end
        end
        if (found) begin
          m_d  = mq[w].pop_front();
          m_c  = w;
          m_v  = 1'b1;
          m_rr = (w + 1) % NCH;
          m_gnt[w]++;
        end else begin
          m_v = 1'b0;
        end
      end
      for (int c = 0; c < NCH; c++)
        if (req_i_valid[c] && sz[c] < DEP) mq[c].push_back(req_i[c]);
    end
  end

  always @(negedge clock) begin
    for (int c = 0; c < NCH; c++)
      chk("ready", 96'(req_i_ready[c]),
          96'(!reset && mq[c].size() < DEP));
    chk("valid", 96'(req_o_valid), 96'(m_v));
    if (m_v) begin
      chk("data", 96'(req_o), 96'(m_d));
      chk("ch", 96'(req_o_ch), 96'(m_c));
    end
`ifdef CACHE_ARB_STATS_EN
    for (int c = 0; c < NCH; c++)
      chk("gcnt", 96'(grant_cnt[c]),
          96'((m_gnt[c] > 2**CW - 1) ? 2**CW - 1 : m_gnt[c]));
`endif
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    req_i_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  logic [3:0] pat [8] = '{4'b0001, 4'b1010, 4'b1111, 4'b0000,
                          4'b0110, 4'b1001, 4'b0100, 4'b1110};

  initial begin
    for (int c = 0; c < NCH; c++) req_i[c] = '0;
    #1 reset = 1'b1;
    cyc(3);
    chk("rst_rdy", 96'(req_i_ready), 96'(4'h0));
    chk("rst_v", 96'(req_o_valid), 96'(0));
    chk("rst_d", 96'(req_o), 96'(0));
    chk("rst_ch", 96'(req_o_ch), 96'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("post_rdy", 96'(req_i_ready), 96'(4'hF));
    cyc();

    // single push on ch2
    req_o_ready = 1'b1;
    req_i[2] = mkreq(2, 1);
    req_i_valid = 4'b0100;
    cyc();
    req_i_valid = '0;
    chk("t1_v0", 96'(req_o_valid), 96'(0));
    cyc();
    chk("t1_v1", 96'(req_o_valid), 96'(1));
    chk("t1_ch", 96'(req_o_ch), 96'(2));
    chk("t1_d", 96'(req_o.addr), 96'(32'h201));
    cyc();
    chk("t1_v2", 96'(req_o_valid), 96'(0));

    // all channels continuously valid
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NCH; c++) req_i[c] = mkreq(c, k);
      req_i_valid = 4'hF;
      cyc();
    end
    req_i_valid = '0;
    cyc(12);
    chk("t2_n", 96'(emitted.size() >= 8), 96'(1));
    for (int i = 0; i < 8; i++)
      if (i < emitted.size()) chk("t2_seq", 96'(emitted[i].ch), 96'(i % 4));

    // stalled output, ch1 pushing every cycle
    do_reset();
    req_o_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_i[1] = mkreq(1, k);
      req_i_valid = 4'b0010;
      cyc();
      if (k >= 2) chk("t3_hold", 96'(req_o.addr), 96'(32'h100));
    end
    chk("t3_rdy", 96'(req_i_ready[1]), 96'(0));
    req_i_valid = '0;
    req_o_ready = 1'b1;
    cyc(5);
    chk("t3_n", 96'(emitted.size()), 96'(3));
    for (int i = 0; i < 3; i++)
      if (i < emitted.size())
        chk("t3_ord", 96'(emitted[i].d.addr), 96'(32'h100 + i));

    // back-to-back A,B,C on ch0
    do_reset();
    for (int k = 10; k < 13; k++) begin
      req_i[0] = mkreq(0, k);
      req_i_valid = 4'b0001;
      cyc();
    end
    req_i_valid = '0;
    cyc(4);
    chk("t4_n", 96'(emitted.size()), 96'(3));
    for (int i = 0; i < 3; i++)
      if (i < emitted.size())
        chk("t4_ord", 96'(emitted[i].d.addr), 96'(10 + i));

    // reset while holding with buffered requests
    do_reset();
    req_o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) req_i[c] = mkreq(c, 20 + k);
      req_i_valid = 4'b1011;
      cyc();
    end
    req_i_valid = '0;
    chk("t5_hold", 96'(req_o_valid), 96'(1));
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("t5_v", 96'(req_o_valid), 96'(0));
    chk("t5_rdy", 96'(req_i_ready), 96'(0));
    @(posedge clock);
    #2 reset = 1'b0;
    req_o_ready = 1'b1;
    cyc(5);
    chk("t5_none", 96'(emitted.size()), 96'(0));
    chk("t5_idle", 96'(req_o_valid), 96'(0));

    // mixed valids with intermittent back-pressure
    do_reset();
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NCH; c++) req_i[c] = mkreq(c, 100 + k);
      req_i_valid = pat[k % 8];
      req_o_ready = (k % 3) != 0;
      cyc();
    end
    req_i_valid = '0;
    req_o_ready = 1'b1;
    cyc(12);
    chk("t6_drain", 96'(req_o_valid), 96'(0));

`ifdef CACHE_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_i[3] = mkreq(3, k);
      req_i_valid = 4'b1000;
      cyc();
    end
    req_i_valid = '0;
    cyc(4);
    chk("t7_sat", 96'(grant_cnt[3]), 96'(3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_req_arb.md
CACHE_REQ_ARB -- requirements
Module: cache_req_arb

Interface
- REQ-001: Parameter NUM_CH, default 4, number of request channels (2..16) feeding one cache port.
- REQ-002: Parameter FIFO_DEPTH, default 2, per-channel buffer entries (power of two, >=2).
- REQ-003: Parameter CNT_W, default 16, width of each grant counter.
- REQ-004: Port clock  in  1  sole clock; all state updates on its rising edge.
- REQ-005: Port reset  in  1  asynchronous, active-high reset.
- REQ-006: Port req_i  in  NUM_CH x req_t  per-channel request payload (req_t from cache_pkg).
- REQ-007: Port req_i_valid  in  NUM_CH  per-channel request valid.
- REQ-008: Port req_i_ready  out  NUM_CH  per-channel accept.
- REQ-009: Port req_o  out  req_t  arbitrated request to cache_top.
- REQ-010: Port req_o_valid  out  1  req_o holds a request.
- REQ-011: Port req_o_ready  in  1  cache accepts req_o.
- REQ-012: Port req_o_ch  out  CH_W (clog2 NUM_CH)  source channel of req_o.
- REQ-013: Port grant_cnt  out  NUM_CH x CNT_W  per-channel grant counts (present only with CACHE_ARB_STATS_EN).

Function
- REQ-014: Each channel SHALL buffer requests in its own FIFO of FIFO_DEPTH entries; req_i_ready[c] SHALL equal NOT full[c], with no same-cycle bypass into a full FIFO.
- REQ-015: A push SHALL occur on channel c when req_i_valid[c] and req_i_ready[c] are both 1 at the rising edge.
- REQ-016: Push and pop on the same channel in the same cycle SHALL both occur, occupancy unchanged.
- REQ-017: Output stage SHALL be a two-state FSM: IDLE (req_o_valid=0) and HOLD (req_o_valid=1).
- REQ-018: IDLE -> HOLD when any FIFO is non-empty; winning head is popped and registered into req_o/req_o_ch.
- REQ-019: HOLD with req_o_ready=1: reload from a non-empty FIFO (stay HOLD) or go IDLE if all empty; HOLD with req_o_ready=0: req_o, req_o_ch and req_o_valid SHALL stay stable.
- REQ-020: Winner SHALL be the first non-empty channel searching upward from rr_ptr with wrap NUM_CH-1 -> 0; rr_ptr SHALL become winner+1 mod NUM_CH on each grant.
- REQ-021: Minimum latency SHALL be 2 cycles: pushed at edge t into an empty FIFO with output IDLE, req_o_valid=1 after edge t+1.
- REQ-022: Sustained throughput SHALL be one request per cycle while req_o_ready=1 and any FIFO non-empty.
- REQ-023: Requests from one channel SHALL leave in arrival order; no request SHALL be dropped or duplicated.

Reset
- REQ-024: On reset assertion, regardless of clock: FSM=IDLE, req_o_valid=0, req_o=0, req_o_ch=0, rr_ptr=0, all FIFOs empty, grant_cnt=0.
- REQ-025: req_i_ready SHALL be 0 while reset is asserted and all 1 in the first cycle after deassertion.
- REQ-026: Reset mid-operation SHALL discard buffered and held requests without emitting them.

Configuration
- REQ-027: Macro CACHE_ARB_STATS_EN defined: grant_cnt[c] increments by 1 on each grant to channel c, saturating at all-ones.
- REQ-028: Macro CACHE_ARB_STATS_EN undefined: grant_cnt port and counters SHALL be absent; all other behaviour identical.

Structure
- REQ-029: req_t and arbiter constants (default NUM_CH, FIFO_DEPTH) SHALL live in cache_pkg.
- REQ-030: Per-channel buffer SHALL be one sub-module, cache_req_fifo, instantiated NUM_CH times.

Verification
- REQ-031: Single push ch2 at cycle 3, req_o_ready=1 -> req_o_valid=1, req_o_ch=2 at cycle 5, one cycle only.
- REQ-032: All 4 channels valid continuously, req_o_ready=1 -> req_o_ch sequence 0,1,2,3,0,... one per cycle.
- REQ-033: req_o_ready=0 for 10 cycles, ch1 pushing every cycle -> req_o stable, req_i_ready[1]=0 after FIFO_DEPTH accepts.
- REQ-034: 3 back-to-back pushes on ch0 payloads 0xA,0xB,0xC -> emitted in order A,B,C, no loss.
- REQ-035: Reset asserted while HOLD and FIFOs non-empty -> req_o_valid=0 immediately; nothing emitted after release until new pushes.
- REQ-036: With CACHE_ARB_STATS_EN, CNT_W=2, 5 grants to ch3 -> grant_cnt[3]=3 (saturated).
